// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter: round-robin arbiter with locked read-modify-write sharing one registered-read RAM
// Ports: clk/reset (sync, active-high); i_req/i_req_we/i_req_lock/i_req_addr/i_req_wdata from requesters;
// o_gnt one-hot combinational grant; o_rvalid/o_rdata read return; o_mem_* registered RAM command,
// i_mem_rdata RAM data; o_lock_err sticky forced-release flag.
module grid_mem_arbiter #(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ-1:0]        i_req_we,
  input  logic [NREQ-1:0]        i_req_lock,
  input  logic [NREQ*ADDR_W-1:0] i_req_addr,
  input  logic [NREQ*DATA_W-1:0] i_req_wdata,
  output logic [NREQ-1:0]        o_gnt,
  output logic [NREQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [DATA_W-1:0]      o_mem_wdata,
  input  logic [DATA_W-1:0]      i_mem_rdata,
  output logic                   o_lock_err
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_MAX);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t r_state, w_next;
  logic [NREQ-1:0] r_owner, r_tag, r_rvalid, w_rr;
  logic [IW-1:0] r_last, w_idx, w_gidx;
  logic [CW-1:0] r_cnt;
  logic r_mem_read, r_mem_write, r_lock_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic w_acc, w_we, w_lock, w_expire;
  // Descending scan so the requester just after r_last is assigned last and wins.
  always_comb begin
    w_rr = '0;
    w_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = IW'((int'(r_last) + i) % NREQ);
      if (i_req[w_idx]) w_rr = NREQ'(1) << w_idx;
    end
  end
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++) if (o_gnt[i]) w_gidx = IW'(i);
  end
  assign w_acc    = |o_gnt;
  assign w_we     = |(o_gnt & i_req_we);
  assign w_lock   = |(o_gnt & i_req_lock);
  assign w_expire = (r_state == LOCKED) && (r_cnt == CW'(LOCK_MAX - 1));
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb w_next = (r_state == IDLE) ? ((w_acc && w_lock) ? LOCKED : IDLE)
                                         : ((w_expire || (w_acc && !w_lock)) ? IDLE : LOCKED);
  always_comb o_gnt = reset ? '0 : (r_state == IDLE) ? w_rr : (r_owner & i_req);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= '0;
      r_last      <= IW'(NREQ - 1);
      r_cnt       <= '0;
      r_lock_err  <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag       <= '0;
      r_rvalid    <= '0;
    end else begin
      r_cnt       <= (r_state == LOCKED) ? r_cnt + 1'b1 : '0;
      r_lock_err  <= r_lock_err | w_expire;
      r_mem_read  <= w_acc & ~w_we;
      r_mem_write <= w_acc & w_we;
      r_tag       <= (w_acc && !w_we) ? o_gnt : '0;
      r_rvalid    <= r_tag;
      if (w_acc && r_state == IDLE) r_owner <= o_gnt;
      if (w_acc) begin
        r_last      <= w_gidx;
        r_mem_addr  <= i_req_addr[w_gidx*ADDR_W +: ADDR_W];
        r_mem_wdata <= i_req_wdata[w_gidx*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset) assert ($onehot0(o_gnt) && (r_state == IDLE || $onehot(r_owner)));
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = i_mem_rdata;
  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_lock_err  = r_lock_err;
endmodule

// File: tb/tb_grid_mem_arbiter.sv
// tb_grid_mem_arbiter: directed and random checks of grid_mem_arbiter against a behavioural model
module tb_grid_mem_arbiter;
  localparam int N = 4, AW = 8, DW = 32, LM = 16;
  logic clk = 1'b0, reset = 1'b1, load = 1'b1;
  logic [N-1:0] req = '0, we = '0, lk = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic mem_read, mem_write, lock_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] init_v [0:255];
  logic [DW-1:0] mm [0:255];
  int errors = 0, checks = 0, cyc = 0;
  bit m_locked = 0, m_err = 0;
  int m_owner = 0, m_last = N - 1, m_held = 0, m_g = -1;
  bit e_rd = 0, e_wr = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd = '0;
  typedef struct {int due; int k; logic [DW-1:0] d;} rd_t;
  rd_t pend[$];
  bit act [N];
  logic [N-1:0] one = 1;

  always #5 clk = ~clk;

  grid_mem_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset), .i_req(req), .i_req_we(we), .i_req_lock(lk),
    .i_req_addr(addr), .i_req_wdata(wdata), .o_gnt(gnt), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_lock_err(lock_err));

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_v[i];
    end else begin
      if (mem_write) ram[mem_addr] <= mem_wdata;
      if (mem_read) mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick();
    if (reset) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int i = 1; i <= N; i++) if (req[(m_last + i) % N]) return (m_last + i) % N;
    return -1;
  endfunction

  task automatic setr(int k, bit r, bit w, bit l, logic [AW-1:0] a, logic [DW-1:0] d);
    req[k] = r; we[k] = w; lk[k] = l;
    addr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  // One clock cycle: check this cycle's outputs against the model, then advance the model over the edge.
  task automatic step();
    logic [N-1:0] eg, erv;
    logic [DW-1:0] ed;
    logic [AW-1:0] a;
    rd_t keep[$];
    #1;
    m_g = pick();
    eg = (m_g < 0) ? '0 : one << m_g;
    chk("gnt", gnt, eg);
    erv = '0; ed = '0;
    foreach (pend[i]) if (pend[i].due == cyc) begin erv[pend[i].k] = 1'b1; ed = pend[i].d; end
    chk("rvalid", rvalid, erv);
    if (erv != 0) chk("rdata", rdata, ed);
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    if (e_wr) chk("mem_wdata", mem_wdata, e_wd);
    chk("lock_err", lock_err, m_err);
    foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
    pend = keep;
    if (reset) begin
      pend.delete();
      m_locked = 0; m_err = 0; m_last = N - 1; m_held = 0;
      e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
    end else begin
      e_rd = 0; e_wr = 0;
      if (m_g >= 0) begin
        a = addr[m_g*AW +: AW];
        e_addr = a;
        e_wd = wdata[m_g*DW +: DW];
        if (we[m_g]) begin mm[a] = e_wd; e_wr = 1; end
        else begin pend.push_back('{cyc + 2, m_g, mm[a]}); e_rd = 1; end
      end
      if (m_locked) begin
        m_held++;
        if (m_held == LM) begin m_locked = 0; m_err = 1; end
        else if (m_g >= 0 && !lk[m_g]) m_locked = 0;
      end else if (m_g >= 0 && lk[m_g]) begin
        m_locked = 1; m_owner = m_g; m_held = 0;
      end
      if (m_g >= 0) m_last = m_g;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin init_v[i] = $urandom; mm[i] = init_v[i]; end
    init_v[5] = 32'h2A; mm[5] = 32'h2A;
    init_v[10] = '1; mm[10] = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    do_reset();
    // 1: single read
    setr(0, 1, 0, 0, 5, 0);
    #1 chk("t1_gnt", gnt, 1);
    step();
    setr(0, 0, 0, 0, 0, 0);
    #1 chk("t1_mem_read", mem_read, 1);
    chk("t1_mem_addr", mem_addr, 5);
    step();
    #1 chk("t1_rvalid", rvalid, 1);
    chk("t1_rdata", rdata, 32'h2A);
    step();
    step();
    // 2: all four requesting reads
    do_reset();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) setr(k, 1, 0, 0, AW'($urandom_range(255)), 0);
      #1 chk("t2_order", gnt, one << (i % 4));
      if (i >= 2) chk("t2_rvalid", rvalid, one << ((i - 2) % 4));
      step();
    end
    for (int k = 0; k < N; k++) setr(k, 0, 0, 0, 0, 0);
    repeat (3) step();
    // 3: locked read-modify-write while req2 waits
    setr(1, 1, 0, 1, 10, 0);
    setr(2, 1, 0, 0, 20, 0);
    #1 chk("t3_first", gnt, 2);
    step();
    setr(1, 0, 0, 0, 0, 0);
    #1 chk("t3_block_a", gnt, 0);
    step();
    #1 chk("t3_block_b", gnt, 0);
    chk("t3_rdata", rdata, 32'hFFFF_FFFF);
    step();
    setr(1, 1, 1, 0, 10, 3);
    #1 chk("t3_write", gnt, 2);
    step();
    setr(1, 0, 0, 0, 0, 0);
    #1 chk("t3_req2", gnt, 4);
    step();
    setr(2, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("t3_ram", ram[10], 3);
    // 4: lock held past LOCK_MAX
    setr(3, 1, 0, 1, 30, 0);
    setr(0, 1, 0, 0, 31, 0);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i <= 16) chk("t4_owner", gnt, 8);
      if (i == 16) chk("t4_err_pre", lock_err, 0);
      if (i == 17) begin chk("t4_req0", gnt, 1); chk("t4_err", lock_err, 1); end
      step();
      if (i == 17) setr(0, 0, 0, 0, 0, 0);
    end
    setr(3, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("t4_sticky", lock_err, 1);
    // 5: reset right after a read accept
    do_reset();
    setr(0, 1, 0, 0, 5, 0);
    step();
    setr(0, 0, 0, 0, 0, 0);
    do_reset();
    #1 chk("t5_rvalid", rvalid, 0);
    chk("t5_mem_read", mem_read, 0);
    chk("t5_lock_err", lock_err, 0);
    setr(0, 1, 0, 0, 1, 0);
    setr(1, 1, 0, 0, 2, 0);
    #1 chk("t5_first", gnt, 1);
    step();
    setr(0, 0, 0, 0, 0, 0);
    step();
    setr(1, 0, 0, 0, 0, 0);
    repeat (3) step();
    // 6: write then read of the same address in one cycle
    do_reset();
    setr(0, 1, 1, 0, 7, 9);
    setr(1, 1, 0, 0, 7, 0);
    #1 chk("t6_first", gnt, 1);
    step();
    setr(0, 0, 0, 0, 0, 0);
    #1 chk("t6_second", gnt, 2);
    step();
    setr(1, 0, 0, 0, 0, 0);
    step();
    #1 chk("t6_rvalid", rvalid, 2);
    chk("t6_rdata", rdata, 9);
    repeat (2) step();
    // random traffic; each requester holds its request until granted
    for (int k = 0; k < N; k++) act[k] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++)
        if (!act[k] && $urandom_range(2) == 0) begin
          act[k] = 1;
          setr(k, 1, 1'($urandom_range(1)), $urandom_range(3) == 0, AW'($urandom_range(15)), $urandom);
        end
      step();
      if (m_g >= 0) begin act[m_g] = 0; setr(m_g, 0, 0, 0, 0, 0); end
    end
    for (int k = 0; k < N; k++) setr(k, 0, 0, 0, 0, 0);
    repeat (20) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
